// File: rtl/oh_bufarb.sv
// One-entry output buffer shared by N requesters through an arbiter.
// Define OH_BUFARB_RR_EN for round-robin; default is fixed priority.
module oh_bufarb #(
  parameter int N  = 4,
  parameter int DW = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [N-1:0]    in_valid,
  input  logic [N*DW-1:0] in_data,
  output logic [N-1:0]    in_ready,
  output logic            out_valid,
  output logic [DW-1:0]   out_data,
  output logic [N-1:0]    out_grant,
  input  logic            out_ready
);

  localparam int PW = (N > 1) ? $clog2(N) : 1;

  logic          valid_q, valid_d;
  logic [DW-1:0] data_q, data_d;
  logic [N-1:0]  grant_q, grant_d;

  logic          open_w;
  logic          found_w;
  logic          xfer_w;
  logic [N-1:0]  gnt_w;
  logic [PW-1:0] widx_w;

  assign open_w = ~valid_q | out_ready;

`ifdef OH_BUFARB_RR_EN
  logic [PW-1:0] ptr_q, ptr_d;

  // Round-robin search: start at ptr, ascend, wrap N-1 -> 0.
  always_comb begin
    int idx;
    idx     = 0;
    gnt_w   = '0;
    widx_w  = '0;
    found_w = 1'b0;
    for (int k = 0; k < N; k++) begin
      idx = int'(ptr_q) + k;
      if (idx >= N) idx = idx - N;
      if (!found_w && in_valid[idx]) begin
        found_w     = 1'b1;
        gnt_w[idx]  = 1'b1;
        widx_w      = PW'(idx);
      end
    end
  end

  // Pointer moves past the winner only when a word is accepted.
  always_comb begin
    ptr_d = ptr_q;
    if (xfer_w) begin
      if (int'(widx_w) == N - 1) ptr_d = '0;
      else                       ptr_d = widx_w + PW'(1);
    end
  end

  // Round-robin pointer register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) ptr_q <= '0;
    else       ptr_q <= ptr_d;
  end
`else
  // Fixed priority: lowest asserted index wins.
  always_comb begin
    gnt_w   = '0;
    widx_w  = '0;
    found_w = 1'b0;
    for (int k = 0; k < N; k++) begin
      if (!found_w && in_valid[k]) begin
        found_w   = 1'b1;
        gnt_w[k]  = 1'b1;
        widx_w    = PW'(k);
      end
    end
  end
`endif

  // Accept strobe is purely control; held low throughout reset.
  assign xfer_w   = open_w & found_w & ~reset;
  assign in_ready = xfer_w ? gnt_w : '0;

  // Next state of the output slot: load, drain or hold.
  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    grant_d = grant_q;
    if (open_w) valid_d = xfer_w;
    if (xfer_w) begin
      data_d  = in_data[int'(widx_w)*DW +: DW];
      grant_d = gnt_w;
    end
  end

  // Output slot registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      grant_q <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
      grant_q <= grant_d;
    end
  end

  assign out_valid = valid_q;
  assign out_data  = data_q;
  assign out_grant = grant_q;

endmodule

// File: tb/tb_oh_bufarb.sv
// Bench for oh_bufarb (N=4, DW=32); expectations follow OH_BUFARB_RR_EN.
// Table vectors plus scoreboard of accepted words.
module tb_oh_bufarb;

`ifdef OH_BUFARB_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  localparam int N  = 4;
  localparam int DW = 32;

  logic            clk = 1'b0;
  logic            reset;
  logic [N-1:0]    in_valid;
  logic [N*DW-1:0] in_data;
  logic [N-1:0]    in_ready;
  logic            out_valid;
  logic [DW-1:0]   out_data;
  logic [N-1:0]    out_grant;
  logic            out_ready;

  oh_bufarb #(.N(N), .DW(DW)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_grant (out_grant),
    .out_ready (out_ready)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] iv;
    logic       ordy;
    logic [3:0] rr_rdy;
    logic [3:0] fp_rdy;
    logic       eov;
  } vec_t;

  typedef struct {
    logic [31:0] data;
    logic [3:0]  grant;
  } sb_t;

  sb_t         q[$];
  logic [31:0] word[N];
  int          n_tests = 0;
  int          n_fail  = 0;
  vec_t        vec[19];

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive_data();
    for (int i = 0; i < N; i++) in_data[i*DW +: DW] = word[i];
  endtask

  task automatic step(input logic [3:0] iv, input logic ordy,
                      input logic [3:0] erdy, input logic eov);
    sb_t e;
    @(negedge clk);
    in_valid  = iv;
    out_ready = ordy;
    drive_data();
    #1;
    check("in_ready", 32'(in_ready), 32'(erdy));
    check("out_valid", 32'(out_valid), 32'(eov));
    if (eov && ordy) begin
      if (q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL sb_empty: got word %h expected none", out_data);
      end else begin
        e = q.pop_front();
        check("out_data", out_data, e.data);
        check("out_grant", 32'(out_grant), 32'(e.grant));
      end
    end
    for (int i = 0; i < N; i++) begin
      if (erdy[i]) begin
        e.data  = word[i];
        e.grant = erdy;
        q.push_back(e);
        word[i] = word[i] + 32'd1;
      end
    end
  endtask

  initial begin
    vec[0]  = '{4'b1111, 1'b1, 4'b0001, 4'b0001, 1'b0};
    vec[1]  = '{4'b1111, 1'b1, 4'b0010, 4'b0001, 1'b1};
    vec[2]  = '{4'b1111, 1'b1, 4'b0100, 4'b0001, 1'b1};
    vec[3]  = '{4'b1111, 1'b1, 4'b1000, 4'b0001, 1'b1};
    vec[4]  = '{4'b1111, 1'b1, 4'b0001, 4'b0001, 1'b1};
    vec[5]  = '{4'b1111, 1'b1, 4'b0010, 4'b0001, 1'b1};
    vec[6]  = '{4'b1111, 1'b1, 4'b0100, 4'b0001, 1'b1};
    vec[7]  = '{4'b1111, 1'b1, 4'b1000, 4'b0001, 1'b1};
    vec[8]  = '{4'b0000, 1'b1, 4'b0000, 4'b0000, 1'b1};
    vec[9]  = '{4'b0000, 1'b1, 4'b0000, 4'b0000, 1'b0};
    vec[10] = '{4'b1000, 1'b1, 4'b1000, 4'b1000, 1'b0};
    vec[11] = '{4'b0101, 1'b1, 4'b0001, 4'b0001, 1'b1};
    vec[12] = '{4'b0101, 1'b1, 4'b0100, 4'b0001, 1'b1};
    vec[13] = '{4'b0000, 1'b1, 4'b0000, 4'b0000, 1'b1};
    vec[14] = '{4'b0000, 1'b0, 4'b0000, 4'b0000, 1'b0};
    vec[15] = '{4'b1010, 1'b1, 4'b1000, 4'b0010, 1'b0};
    vec[16] = '{4'b1010, 1'b1, 4'b0010, 4'b0010, 1'b1};
    vec[17] = '{4'b1010, 1'b1, 4'b1000, 4'b0010, 1'b1};
    vec[18] = '{4'b1010, 1'b1, 4'b0010, 4'b0010, 1'b1};

    for (int i = 0; i < N; i++) word[i] = {8'hC0 + 8'(i), 24'h000100};

    // Reset held with all requesters asserting.
    reset     = 1'b1;
    in_valid  = 4'b1111;
    out_ready = 1'b1;
    drive_data();
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check("rst_in_ready", 32'(in_ready), 32'd0);
      check("rst_out_valid", 32'(out_valid), 32'd0);
      check("rst_out_data", out_data, 32'd0);
      check("rst_out_grant", 32'(out_grant), 32'd0);
    end
    in_valid = 4'b0000;
    reset    = 1'b0;

    // Table: rotation / fixed priority, drain, wrap-skip, starvation.
    for (int k = 0; k < 19; k++)
      step(vec[k].iv, vec[k].ordy,
           RR ? vec[k].rr_rdy : vec[k].fp_rdy, vec[k].eov);

    // Backpressure: req 2 word held while downstream stalls.
    word[2] = 32'hA5A5A5A5;
    step(4'b0100, 1'b1, 4'b0100, 1'b1);
    for (int c = 0; c < 5; c++) begin
      step(4'b1111, 1'b0, 4'b0000, 1'b1);
      check("bp_data", out_data, 32'hA5A5A5A5);
      check("bp_grant", 32'(out_grant), 32'h4);
    end
    step(4'b0000, 1'b1, 4'b0000, 1'b1);
    step(4'b0000, 1'b1, 4'b0000, 1'b0);
    check("drain_data", out_data, 32'hA5A5A5A5);
    check("drain_grant", 32'(out_grant), 32'h4);
    check("bp_once", 32'(q.size()), 32'd0);

    // Reset in the middle of a held word discards it.
    step(4'b0001, 1'b0, 4'b0001, 1'b0);
    @(posedge clk);
    #2;
    check("pre_rst_valid", 32'(out_valid), 32'd1);
    reset    = 1'b1;
    in_valid = 4'b0000;
    #1;
    check("mid_rst_valid", 32'(out_valid), 32'd0);
    check("mid_rst_data", out_data, 32'd0);
    check("mid_rst_grant", 32'(out_grant), 32'd0);
    q.delete();
    @(negedge clk);
    reset = 1'b0;
    step(4'b0000, 1'b1, 4'b0000, 1'b0);
    step(4'b0000, 1'b1, 4'b0000, 1'b0);

    // First arbitration after reset starts at requester 0.
    step(4'b1111, 1'b1, 4'b0001, 1'b0);
    step(4'b0000, 1'b1, 4'b0000, 1'b1);
    step(4'b0000, 1'b1, 4'b0000, 1'b0);
    check("sb_final", 32'(q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/oh_bufarb.md
OH_BUFARB -- requirements
Module: oh_bufarb

Interface
REQ-001 Parameter N, default 4: number of requesters, legal range 1..32.
REQ-002 Parameter DW, default 32: data width per requester.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 in_valid  input  N  per-requester request/valid.
REQ-006 in_data  input  N*DW  requester i data at bits [i*DW +: DW].
REQ-007 in_ready  output  N  one-hot (or zero) accept strobe per requester, combinational.
REQ-008 out_valid  output  1  registered output holds valid data.
REQ-009 out_data  output  DW  registered output data.
REQ-010 out_grant  output  N  registered one-hot index of the requester that owns out_data.
REQ-011 out_ready  input  1  downstream accepts out_data when high with out_valid.

Function
REQ-012 Block SHALL be a one-entry output buffer shared by N requesters via arbitration.
REQ-013 Register slot "open" SHALL be defined as (~out_valid | out_ready).
REQ-014 When open and any in_valid is high, exactly one winner SHALL get in_ready=1; all other in_ready=0.
REQ-015 When not open, in_ready SHALL be all zero.
REQ-016 On a transfer (in_valid[w] & in_ready[w]), the next edge SHALL load out_data=in_data[w], out_grant=one-hot w, out_valid=1.
REQ-017 Latency SHALL be exactly 1 cycle from in-side transfer to out_valid.
REQ-018 When open and no in_valid, the next edge SHALL set out_valid=0; out_data and out_grant SHALL hold.
REQ-019 When out_valid=1 and out_ready=0, out_valid, out_data and out_grant SHALL hold unchanged.
REQ-020 Simultaneous out_ready and new transfer SHALL give back-to-back throughput of one word per cycle.
REQ-021 Requesters SHALL hold in_valid and in_data stable until accepted; the block does not support in_valid withdrawal.
REQ-022 Round-robin pointer ptr (range 0..N-1): search starts at ptr, ascending, wrapping N-1 -> 0.
REQ-023 After a transfer by winner w, ptr SHALL become w+1, wrapping to 0 when w=N-1; otherwise ptr holds.
REQ-024 With N=1, block SHALL behave as a plain valid/ready pipeline register; ptr stays 0.
REQ-025 in_ready SHALL depend only on in_valid, ptr, out_valid and out_ready (no data path).

Reset
REQ-026 While reset is high: out_valid=0, out_data=0, out_grant=0, ptr=0; in_ready SHALL be all zero.
REQ-027 Reset asserted mid-transfer SHALL discard the held word; no transfer is reported on the deassertion edge.
REQ-028 First arbitration after reset release SHALL start at requester 0.

Configuration
REQ-029 Macro OH_BUFARB_RR_EN defined: round-robin arbitration per REQ-022/023.
REQ-030 Macro OH_BUFARB_RR_EN undefined: fixed priority, lowest asserted index wins; ptr logic not built; all other requirements unchanged.

Verification
REQ-031 Reset: assert reset with in_valid=4'b1111 -> in_ready=0, out_valid=0, out_data=0, out_grant=0 throughout.
REQ-032 Rotation (RR_EN, N=4): in_valid=4'b1111, out_ready=1 for 8 cycles -> out_grant sequence 0001,0010,0100,1000,0001,0010,0100,1000, one word per cycle.
REQ-033 Backpressure: load word 0xA5A5A5A5 from req 2, hold out_ready=0 for 5 cycles -> out_data/out_grant/out_valid stable, in_ready=0; release -> word consumed exactly once.
REQ-034 Wrap/skip (RR_EN): after grant to req 3, in_valid=4'b0101 -> next grant req 0, then req 2.
REQ-035 Fixed priority (macro off): in_valid=4'b1010 held, out_ready=1 -> req 1 granted every cycle, req 3 starved.
REQ-036 Drain: single transfer then in_valid=0, out_ready=1 -> out_valid high for exactly 1 cycle, then 0 with out_data held.
